// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style multiply/divide unit with HI/LO registers.
// Shift-add multiply and restoring divide, one bit per cycle, on magnitudes;
// sign correction happens in the FIX state.
// Build option: define MULDIV_FAST_MUL_EN for a single-cycle combinational
// multiplier (divide stays iterative).
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2*WIDTH-1:0] acc;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]   opd;      // latched multiplicand or divisor magnitude
   logic               neg_q;    // negate product / quotient in FIX
   logic               neg_r;    // negate remainder in FIX
   logic               is_div;

   logic               sgn;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_next;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] div_next;
   logic [WIDTH-1:0]   q_fix;
   logic [WIDTH-1:0]   r_fix;
   logic [2*WIDTH-1:0] p_fix;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] fast_prod;
`endif

   // Operand magnitudes, one iteration step of each algorithm, and sign fix-up
   always_comb begin
      sgn       = ~op[0];
      mag_a     = (sgn && a[WIDTH-1]) ? -a : a;
      mag_b     = (sgn && b[WIDTH-1]) ? -b : b;
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
      mul_next  = {mul_sum, acc[WIDTH-1:1]};
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opd};
      div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                  : {div_diff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};
      q_fix     = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      r_fix     = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      p_fix     = neg_q ? -acc : acc;
`ifdef MULDIV_FAST_MUL_EN
      ext_a     = {{WIDTH{sgn & a[WIDTH-1]}}, a};
      ext_b     = {{WIDTH{sgn & b[WIDTH-1]}}, b};
      fast_prod = ext_a * ext_b;
`endif
   end

   // Control FSM, iteration datapath and architectural HI/LO registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         opd         <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         is_div      <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     OP_MTHI: begin
                        hi   <= a;
                        done <= 1'b1;
                     end
                     OP_MTLO: begin
                        lo   <= a;
                        done <= 1'b1;
                     end
                     OP_MULT, OP_MULTU: begin
`ifdef MULDIV_FAST_MUL_EN
                        hi   <= fast_prod[2*WIDTH-1:WIDTH];
                        lo   <= fast_prod[WIDTH-1:0];
                        done <= 1'b1;
`else
                        state  <= MUL;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        is_div <= 1'b0;
                        acc    <= {{WIDTH{1'b0}}, mag_b};
                        opd    <= mag_a;
                        neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r  <= 1'b0;
`endif
                     end
                     OP_DIV, OP_DIVU: begin
                        if (b == '0) begin
                           hi          <= a;
                           lo          <= '1;
                           done        <= 1'b1;
                           div_by_zero <= 1'b1;
                        end else begin
                           state  <= DIV;
                           busy   <= 1'b1;
                           cnt    <= '0;
                           is_div <= 1'b1;
                           acc    <= {{WIDTH{1'b0}}, mag_a};
                           opd    <= mag_b;
                           neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                           neg_r  <= sgn & a[WIDTH-1];
                        end
                     end
                     default: ;
                  endcase
               end
            end
            MUL: begin
               acc <= mul_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= FIX;
            end
            DIV: begin
               acc <= div_next;
               cnt <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) state <= FIX;
            end
            FIX: begin
               if (is_div) begin
                  hi <= r_fix;
                  lo <= q_fix;
               end else begin
                  hi <= p_fix[2*WIDTH-1:WIDTH];
                  lo <= p_fix[WIDTH-1:0];
               end
               cnt   <= '0;
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit (WIDTH=32): directed vectors push expected
// HI/LO/flag and due cycle; a monitor pops and compares on every done pulse.
module tb_muldiv_unit;

   localparam int unsigned W = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int   MUL_LAT  = 0;
   localparam logic MUL_BUSY = 1'b0;
`else
   localparam int   MUL_LAT  = 33;
   localparam logic MUL_BUSY = 1'b1;
`endif
   localparam int DIV_LAT = 33;

   logic         clk   = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   op    = 3'd0;
   logic [W-1:0] a     = '0;
   logic [W-1:0] b     = '0;
   logic         busy;
   logic         done;
   logic         div_by_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dbz;
      int           due;
      string        nm;
   } exp_t;

   exp_t         sb[$];
   int           cyc    = 0;
   int           n_cmp  = 0;
   int           n_fail = 0;
   logic [W-1:0] m_hi   = '0;
   logic [W-1:0] m_lo   = '0;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (div_by_zero && !done) begin
         n_cmp++;
         n_fail++;
         $display("FAIL dbz_without_done: div_by_zero=1 while done=0");
      end
      if (done) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_done: done=1 at cycle %0d with nothing pending", cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk({e.nm, "_hi"},  64'(hi), 64'(e.hi));
            chk({e.nm, "_lo"},  64'(lo), 64'(e.lo));
            chk({e.nm, "_dbz"}, 64'(div_by_zero), 64'(e.dbz));
            chk({e.nm, "_cyc"}, 64'(cyc), 64'(e.due));
         end
      end
   end

   // Issue one request (called at a negedge); returns at the negedge after acceptance
   task automatic issue(input string nm, input logic [2:0] o, input logic [W-1:0] xa,
                        input logic [W-1:0] xb, input logic [W-1:0] eh, input logic [W-1:0] el,
                        input logic ed, input int lat, input logic eb);
      exp_t e;
      e.hi  = eh;
      e.lo  = el;
      e.dbz = ed;
      e.due = cyc + 1 + lat;
      e.nm  = nm;
      sb.push_back(e);
      m_hi  = eh;
      m_lo  = el;
      op    = o;
      a     = xa;
      b     = xb;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
      chk({nm, "_busy"}, 64'(busy), 64'(eb));
   endtask

   task automatic wait_drain(input string nm);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         if (sb.size() == 0) break;
      end
      chk({nm, "_drain"}, 64'(sb.size()), 64'(0));
      @(negedge clk);
   endtask

   task automatic wait_done(input string nm);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (done) break;
      end
      chk({nm, "_done_seen"}, 64'(done), 64'(1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      logic seen;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_hi",   64'(hi),   64'(0));
      chk("rst_lo",   64'(lo),   64'(0));
      reset = 1'b0;
      @(negedge clk);

      issue("mult_neg", 3'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, MUL_LAT, MUL_BUSY);
      wait_drain("mult_neg");
      issue("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, MUL_LAT, MUL_BUSY);
      wait_drain("multu_max");

      // back-to-back: divide-by-zero accepted in the done cycle of the signed divide
      issue("div_m7_2", 3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, DIV_LAT, 1'b1);
      wait_done("div_m7_2");
      issue("divu_by0", 3'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
      wait_drain("divu_by0");

      issue("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, DIV_LAT, 1'b1);
      wait_drain("div_ovf");
      issue("divu_100_7", 3'd3, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, DIV_LAT, 1'b1);
      wait_drain("divu_100_7");
      issue("div_7_m2", 3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, DIV_LAT, 1'b1);
      wait_drain("div_7_m2");
      issue("mult_7_m6", 3'd0, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0, MUL_LAT, MUL_BUSY);
      wait_drain("mult_7_m6");
      issue("mtlo", 3'd5, 32'hCAFEBABE, 32'h00000000, m_hi, 32'hCAFEBABE, 1'b0, 0, 1'b0);
      wait_drain("mtlo");
      issue("div_by0", 3'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 0, 1'b0);
      wait_drain("div_by0");
      issue("multu_2p32", 3'd1, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0, MUL_LAT, MUL_BUSY);
      wait_drain("multu_2p32");
      issue("divu_max_1", 3'd3, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, DIV_LAT, 1'b1);
      wait_drain("divu_max_1");

      // no-op opcode: no done (monitor would flag one), no register change
      op = 3'd6; a = 32'h11111111; b = 32'h22222222; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("nop_busy", 64'(busy), 64'(0));
      repeat (5) @(negedge clk);
      chk("nop_hi", 64'(hi), 64'(m_hi));
      chk("nop_lo", 64'(lo), 64'(m_lo));

      // start while busy is ignored; reset mid-operation aborts without done
      issue("divu_abort", 3'd3, 32'h000003E8, 32'h00000003, 32'h00000000, 32'h00000000, 1'b0, DIV_LAT, 1'b1);
      repeat (3) @(negedge clk);
      op = 3'd4; a = 32'hDEADBEEF; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      chk("ign_busy", 64'(busy), 64'(1));
      chk("ign_hi",   64'(hi),   64'(32'h00000000));
      repeat (4) @(negedge clk);
      reset = 1'b1;
      sb.delete();
      #1;
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_hi",   64'(hi),   64'(0));
      chk("abort_lo",   64'(lo),   64'(0));
      m_hi = '0;
      m_lo = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || busy) seen = 1'b1;
      end
      chk("abort_quiet", 64'(seen), 64'(0));
      issue("mthi", 3'd4, 32'h12345678, 32'h00000000, 32'h12345678, 32'h00000000, 1'b0, 0, 1'b0);
      wait_drain("mthi");

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
